keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
// Matrix-keypad scanner: the input-side counterpart of the multiplexed 7-seg display scan.
// Drives a 4x4 keypad one row at a time (active-low) and samples the active-low columns.
// Debounces the result over whole scan frames and reports one registered key code per press.
// Sits between the board keypad pins and the control logic that consumes digit entries.
// PARAMETERS
// SCAN_DIV  3000  clk100MHZ cycles per row step; legal range >= 4
// DEBOUNCE  3     consecutive identical frames needed to accept a press or a release; legal range >= 2
// PORTS
// clk100MHZ    in   1  system clock; all logic on rising edge
// rst_n        in   1  reset, asynchronous, active-low
// col_n        in   4  keypad columns, active-low, asynchronous to clk100MHZ
// row_n        out  4  keypad row drive, active-low, exactly one bit low at all times
// key_code     out  4  last accepted key, row*4+col; holds its value until the next accept
// key_valid    out  1  one-cycle pulse when a new key is accepted
// key_down     out  1  high while the accepted key is considered held
// key_release  out  1  one-cycle pulse when the release is accepted
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - row_n=4'b1110, i.e. row 0 is driven.
//   - Divider, row index, accumulator and debounce counter are all 0.
//   - FSM goes to IDLE.
//   - key_code=0; key_valid, key_down and key_release are all 0.
// - col_n passes through a 2-flop synchronizer; call the result cs.
// - Divider counts 0..SCAN_DIV-1 and wraps. tick=1 on the cycle where the count equals SCAN_DIV-1.
// - On each tick:
//   - Sample ~cs as the column hits of the current row.
//   - Then advance the row index 0->1->2->3->0 and update row_n.
//   - Each row is therefore driven for a full SCAN_DIV period before it is sampled.
// - Frame = the 4 ticks for rows 0..3. The accumulator collects the hit count and the code of the first hit.
//   - Code of a hit = row*4 + col index; column 0 = col_n[0].
// - On the tick that samples row 3, the frame result includes that row's hits:
//   - NONE: 0 hits.
//   - SINGLE(k): exactly 1 hit.
//   - MULTI: 2 or more hits. MULTI is never accepted as a key.
//   - The accumulator then clears.
// - Debounce FSM. It steps only on frame-end ticks, and cnt is 2 bits wider than needed for DEBOUNCE.
//   - IDLE:
//     - SINGLE(k) -> cand=k, cnt=1, go to PRESS_CHK.
//     - Any other result -> stay in IDLE.
//   - PRESS_CHK:
//     - SINGLE(cand) -> cnt+1. When cnt+1 == DEBOUNCE: go to HELD, key_code<=cand, key_valid=1, key_down=1.
//     - Any other result (NONE, MULTI, or a different key) -> go to IDLE, cnt=0.
//   - HELD:
//     - NONE -> cnt=1, go to RELEASE_CHK.
//     - SINGLE (any key) or MULTI -> stay in HELD. Rollover is ignored; the key must be released first.
//   - RELEASE_CHK:
//     - NONE -> cnt+1. When cnt+1 == DEBOUNCE: go to IDLE, key_down=0, key_release=1.
//     - Any key (SINGLE or MULTI) -> back to HELD, cnt=0. No new key_valid is issued.
// - Output timing:
//   - key_valid and key_release are registered. Each is high for exactly the one cycle after its frame-end tick.
//   - key_code updates in the same cycle that key_valid rises.
// - Latency: a press held steadily from a frame boundary gives key_valid DEBOUNCE frames plus 1 cycle later.
//   - Frame = 4*SCAN_DIV cycles.
//   - A press that starts mid-frame may add up to 1 more frame.
// - key_valid and key_release are never high in the same cycle, and never in consecutive frames.
// - Reset mid-operation: everything aborts and no pulse is emitted. Scanning restarts at row 0 with a fresh frame.
// TESTING
// Bench: SCAN_DIV=4, DEBOUNCE=3, so 1 frame = 16 cycles. A keypad model drives col_n[c]=0 while row_n[r]=0 and key (r,c) is pressed; otherwise col_n is all 1.
// 1. Reset, then run 40 cycles with no key:
//    - row_n walks 1110 -> 1101 -> 1011 -> 0111 -> 1110, each value held 4 cycles.
//    - All outputs stay 0.
// 2. Hold key (2,1) from a frame boundary for 6 frames:
//    - Exactly one key_valid pulse, after the 3rd frame end, with key_code=9.
//    - key_down=1 from that cycle on.
// 3. Press (0,3) for 2 frames, release 1 frame, press 2 more frames, then release:
//    - No key_valid.
//    - key_code stays at its previous value.
// 4. Hold keys (0,0) and (1,1) together for 5 frames:
//    - No key_valid and key_down=0 (MULTI).
// 5. From HELD on key 5:
//    - Release 2 frames, then re-press: no key_release, no new key_valid, key_down stays 1.
//    - Then release 3 frames: one key_release pulse and key_down=0.
// 6. Press key 14 for 2 frames (FSM in PRESS_CHK), pulse rst_n low for 1 cycle, keep the key held:
//    - Outputs go to 0 immediately and row_n=1110.
//    - key_valid with code 14 arrives 3 full frames after reset.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame-based debounce.
// Rows are driven active-low one at a time. Column hits are gathered into a
// per-frame result. A small FSM turns stable frame results into press and
// release events.
module keypad_scan #(
    parameter int SCAN_DIV = 3000,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk100MHZ,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       key_release
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // Two spare bits keep cnt+1 from wrapping before it can equal DEBOUNCE.
    localparam int CW = $clog2(DEBOUNCE + 1) + 2;

    // Frame result: hits saturates at 2 (MULTI); code is the first hit in scan order.
    typedef struct packed {
        logic [1:0] hits;
        logic [3:0] code;
    } frame_t;

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    logic [1:0][3:0] sync_pipe;
    logic [3:0]      cs;
    logic [DW-1:0]   div;
    logic [1:0]      row_idx;
    logic            tick;
    logic            frame_end;
    frame_t          acc;
    frame_t          frame;
    logic [2:0]      row_cnt;
    logic [1:0]      row_first;
    logic            row_any;
    logic [2:0]      sum;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [3:0]      cand;
    logic            is_none;
    logic            is_single;

    assign cs        = sync_pipe[1];
    assign tick      = (div == DW'(SCAN_DIV - 1));
    assign frame_end = tick && (row_idx == 2'd3);
    assign cnt_inc   = cnt + CW'(1);
    assign is_none   = (frame.hits == 2'd0);
    assign is_single = (frame.hits == 2'd1);

    // Two-flop synchronizer for the asynchronous column inputs (idle = all high).
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            sync_pipe <= {4'hF, 4'hF};
        end else begin
            sync_pipe[0] <= col_n;
            sync_pipe[1] <= sync_pipe[0];
        end
    end

    // Row-step divider and row drive: sample happens on tick, then the row advances.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            div     <= '0;
            row_idx <= 2'd0;
            row_n   <= 4'b1110;
        end else if (tick) begin
            div     <= '0;
            row_idx <= row_idx + 2'd1;
            row_n   <= ~(4'b0001 << (row_idx + 2'd1));
        end else begin
            div <= div + DW'(1);
        end
    end

    // Decode the current row's hits and merge them with the frame accumulator.
    always_comb begin
        row_cnt   = 3'd0;
        row_first = 2'd0;
        row_any   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (!cs[c]) begin
                row_cnt = row_cnt + 3'd1;
                if (!row_any) begin
                    row_first = 2'(c);
                    row_any   = 1'b1;
                end
            end
        end
        sum        = {1'b0, acc.hits} + row_cnt;
        frame.hits = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        frame.code = (acc.hits == 2'd0) ? {row_idx, row_first} : acc.code;
    end

    // Frame accumulator: collect hits on each tick, clear after the row-3 sample.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (tick) begin
            acc <= (row_idx == 2'd3) ? frame_t'('0) : frame;
        end
    end

    // Debounce FSM, stepped on frame ends; event pulses last one cycle.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= 4'd0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_down    <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: begin
                        if (is_single) begin
                            cand  <= frame.code;
                            cnt   <= CW'(1);
                            state <= PRESS_CHK;
                        end
                    end
                    PRESS_CHK: begin
                        if (is_single && frame.code == cand) begin
                            if (cnt_inc == CW'(DEBOUNCE)) begin
                                state     <= HELD;
                                cnt       <= '0;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    HELD: begin
                        // Rollover to another key is ignored until a clean release.
                        if (is_none) begin
                            cnt   <= CW'(1);
                            state <= RELEASE_CHK;
                        end
                    end
                    RELEASE_CHK: begin
                        if (is_none) begin
                            if (cnt_inc == CW'(DEBOUNCE)) begin
                                state       <= IDLE;
                                cnt         <= '0;
                                key_down    <= 1'b0;
                                key_release <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= HELD;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=3 (one frame = 16 cycles).
// Stimulus pushes expected pulses (kind, code, cycle) into a queue; a monitor
// pops and compares whenever key_valid or key_release fires.
module tb_keypad_scan;

    logic        clk100MHZ;
    logic        rst_n;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic        key_release;
    logic [15:0] pressed;
    int          cyc;
    int          checks;
    int          errors;

    typedef struct {
        bit         is_rel;
        logic [3:0] code;
        int         at;
    } exp_t;

    exp_t q[$];

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk100MHZ  (clk100MHZ),
        .rst_n      (rst_n),
        .col_n      (col_n),
        .row_n      (row_n),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_down   (key_down),
        .key_release(key_release)
    );

    initial clk100MHZ = 1'b0;
    always #5 clk100MHZ = ~clk100MHZ;

    // Keypad model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    // Cycles since the last reset release; frame ends fall on multiples of 16.
    always @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: every pulse must match the next expected event, including its cycle.
    always @(negedge clk100MHZ) begin
        if (rst_n) begin
            if (key_valid && key_release) begin
                checks++;
                errors++;
                $display("FAIL both_pulses cyc=%0d valid=1 release=1", cyc);
            end else if (key_valid || key_release) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d valid=%0b release=%0b code=%0d",
                             cyc, key_valid, key_release, key_code);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.is_rel != key_release || e.at != cyc ||
                        (!e.is_rel && e.code != key_code)) begin
                        errors++;
                        $display("FAIL pulse got rel=%0b code=%0d cyc=%0d want rel=%0b code=%0d cyc=%0d",
                                 key_release, key_code, cyc, e.is_rel, e.code, e.at);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (16 * n) @(posedge clk100MHZ);
        #1;
    endtask

    task automatic align();
        @(posedge clk100MHZ);
        #1;
        while (cyc % 16 != 0) begin
            @(posedge clk100MHZ);
            #1;
        end
    endtask

    task automatic push(input bit is_rel, input logic [3:0] code, input int at);
        exp_t e;
        e.is_rel = is_rel;
        e.code   = code;
        e.at     = at;
        q.push_back(e);
    endtask

    initial begin
        logic [3:0] er;
        checks  = 0;
        errors  = 0;
        pressed = 16'h0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk100MHZ);
        #1;
        chk("rst_row_n", row_n, 4'b1110);
        chk("rst_outputs", {key_code, key_valid, key_down, key_release}, 7'd0);
        rst_n = 1'b1;

        // 1: idle scan, row walks every 4 cycles, outputs stay quiet
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk100MHZ);
            #1;
            er = 4'b1111;
            er[(n / 4) % 4] = 1'b0;
            chk("row_walk", row_n, er);
            chk("idle_outputs", {key_code, key_valid, key_down, key_release}, 7'd0);
        end
        align();

        // 2: steady press of key 9 for 6 frames, then release
        pressed[9] = 1'b1;
        push(1'b0, 4'd9, cyc + 48);
        frames(6);
        chk("t2_key_down", key_down, 1'b1);
        chk("t2_key_code", key_code, 4'd9);
        pressed = 16'h0;
        push(1'b1, 4'd0, cyc + 48);
        frames(4);
        chk("t2_released", key_down, 1'b0);

        // 3: bouncy press of key 3 never reaches DEBOUNCE frames
        pressed[3] = 1'b1;
        frames(2);
        pressed = 16'h0;
        frames(1);
        pressed[3] = 1'b1;
        frames(2);
        pressed = 16'h0;
        frames(2);
        chk("t3_key_code", key_code, 4'd9);
        chk("t3_key_down", key_down, 1'b0);

        // 4: two keys at once is MULTI, never accepted
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        frames(5);
        chk("t4_key_down", key_down, 1'b0);
        chk("t4_key_code", key_code, 4'd9);
        pressed = 16'h0;
        frames(1);

        // 5: key 5 held, short release is absorbed, long release is reported
        pressed[5] = 1'b1;
        push(1'b0, 4'd5, cyc + 48);
        frames(4);
        chk("t5_held", key_down, 1'b1);
        pressed = 16'h0;
        frames(2);
        chk("t5_release_chk", key_down, 1'b1);
        pressed[5] = 1'b1;
        frames(2);
        chk("t5_repressed", key_down, 1'b1);
        pressed = 16'h0;
        push(1'b1, 4'd0, cyc + 48);
        frames(4);
        chk("t5_released", key_down, 1'b0);
        chk("t5_key_code", key_code, 4'd5);

        // 6: reset during PRESS_CHK on key 14, key stays held through reset
        pressed[14] = 1'b1;
        frames(2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_row_n", row_n, 4'b1110);
        chk("t6_rst_outputs", {key_code, key_valid, key_down, key_release}, 7'd0);
        @(posedge clk100MHZ);
        #1;
        rst_n = 1'b1;
        push(1'b0, 4'd14, 48);
        frames(4);
        chk("t6_key_code", key_code, 4'd14);
        chk("t6_key_down", key_down, 1'b1);
        pressed = 16'h0;
        push(1'b1, 4'd0, cyc + 48);
        frames(4);
        chk("t6_released", key_down, 1'b0);

        // every expected pulse must have been seen
        chk("pending_events", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
